// File: rtl/nes_pad_reader.sv
// NES controller reader: pulses latch, clocks out 8 serial bits and publishes an
// active-high, registered button vector with a one-cycle valid strobe.
`timescale 1ns/1ps
module nes_pad_reader #(
  parameter int LATCH_CYCLES = 300,
  parameter int HALF_BIT     = 150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trigger,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       pad_present,
  output logic       busy
);

  // state    | meaning
  // IDLE     | waiting for trigger
  // LATCH    | nes_latch high for LATCH_CYCLES
  // BIT_LOW  | nes_clk low, sample bit on last cycle
  // BIT_HIGH | nes_clk high, controller shifts next bit
  // DONE     | publish buttons, pulse valid
  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_BIT_LOW, S_BIT_HIGH, S_DONE
  } state_t;

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_BIT) ? LATCH_CYCLES : HALF_BIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LATCH_LOAD = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             data_meta_q, data_meta_d;
  logic             data_sync_q, data_sync_d;
  logic             nes_latch_q, nes_latch_d;
  logic             nes_clk_q, nes_clk_d;
  logic [7:0]       buttons_q, buttons_d;
  logic             valid_q, valid_d;
  logic             pad_present_q, pad_present_d;
  logic             busy_q, busy_d;
  logic             cnt_tc;

  assign cnt_tc = (cnt_q == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    buttons_d     = buttons_q;
    pad_present_d = pad_present_q;
    valid_d       = 1'b0;
    data_meta_d   = nes_data;
    data_sync_d   = data_meta_q;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_LATCH;
          cnt_d   = LATCH_LOAD;
        end
      end
      S_LATCH: begin
        if (cnt_tc) begin
          state_d = S_BIT_LOW;
          cnt_d   = HALF_LOAD;
          idx_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BIT_LOW: begin
        if (cnt_tc) begin
          // controller drives active-low; store as active-high
          shift_d[idx_q] = ~data_sync_q;
          cnt_d          = HALF_LOAD;
          state_d        = (idx_q == 3'd7) ? S_DONE : S_BIT_HIGH;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_BIT_HIGH: begin
        if (cnt_tc) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = HALF_LOAD;
          state_d = S_BIT_LOW;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        state_d = S_IDLE;
        // every line low means a floating/pulled-down input, not a real pad
        if (shift_q == 8'hFF) begin
          buttons_d     = 8'h00;
          pad_present_d = 1'b0;
        end else begin
          buttons_d     = shift_q;
          pad_present_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    nes_latch_d = (state_d == S_LATCH);
    nes_clk_d   = (state_d == S_BIT_HIGH);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'h00;
      data_meta_q   <= 1'b1;
      data_sync_q   <= 1'b1;
      nes_latch_q   <= 1'b0;
      nes_clk_q     <= 1'b0;
      buttons_q     <= 8'h00;
      valid_q       <= 1'b0;
      pad_present_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_meta_q   <= data_meta_d;
      data_sync_q   <= data_sync_d;
      nes_latch_q   <= nes_latch_d;
      nes_clk_q     <= nes_clk_d;
      buttons_q     <= buttons_d;
      valid_q       <= valid_d;
      pad_present_q <= pad_present_d;
      busy_q        <= busy_d;
    end
  end

  assign nes_latch   = nes_latch_q;
  assign nes_clk     = nes_clk_q;
  assign buttons     = buttons_q;
  assign valid       = valid_q;
  assign pad_present = pad_present_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: table-driven reads, randomized reads against a
// controller model, plus mid-read trigger and reset sequences.
`timescale 1ns/1ps
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trigger = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk;
  logic [7:0] buttons;
  logic       valid, pad_present, busy;

  int checks = 0;
  int errors = 0;

  nes_pad_reader #(.LATCH_CYCLES(6), .HALF_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .nes_data(nes_data),
    .nes_latch(nes_latch), .nes_clk(nes_clk), .buttons(buttons),
    .valid(valid), .pad_present(pad_present), .busy(busy)
  );

  always #20 clk = ~clk;

  // controller model: latch reloads, each nes_clk rise presents the next button
  logic [7:0] pad_btn = 8'h00;
  logic       no_pad  = 1'b0;
  logic [3:0] sh_idx  = 4'd0;

  always @(posedge nes_clk or posedge nes_latch) begin
    if (nes_latch)          sh_idx <= 4'd0;
    else if (sh_idx < 4'd8) sh_idx <= sh_idx + 4'd1;
  end

  assign nes_data = no_pad ? 1'b0 : (sh_idx[3] ? 1'b1 : ~pad_btn[sh_idx[2:0]]);

  function automatic logic [7:0] ref_buttons(input logic np, input logic [7:0] pressed);
    logic [7:0] rd;
    rd = np ? 8'hFF : pressed;
    return (rd == 8'hFF) ? 8'h00 : rd;
  endfunction

  function automatic logic ref_present(input logic np, input logic [7:0] pressed);
    return !np && (pressed != 8'hFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one read: trigger sampled at edge N, observe 80 cycles (ends just after N+79)
  task automatic read_check(input string name, input logic np, input logic [7:0] pressed,
                            input logic [7:0] eb, input logic ep, input bit inject);
    int latch_cnt, rise_cnt, valid_cnt, valid_at, busy_cnt;
    logic prev_clk;
    logic [7:0] btn_v;
    logic pad_v;
    latch_cnt = 0; rise_cnt = 0; valid_cnt = 0; valid_at = -1; busy_cnt = 0;
    prev_clk = 1'b0; btn_v = 8'h00; pad_v = 1'b0;
    no_pad = np; pad_btn = pressed;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      trigger = inject && (c == 9 || c == 39);
      if (nes_latch) latch_cnt++;
      if (nes_clk && !prev_clk) rise_cnt++;
      prev_clk = nes_clk;
      if (busy) busy_cnt++;
      if (valid) begin
        valid_cnt++;
        if (valid_at < 0) begin
          valid_at = c; btn_v = buttons; pad_v = pad_present;
        end
      end
    end
    trigger = 1'b0;
    check({name, "_valid_at"},  valid_at,  67);
    check({name, "_valid_cnt"}, valid_cnt, 1);
    check({name, "_latch_cyc"}, latch_cnt, 6);
    check({name, "_clk_pulses"}, rise_cnt, 7);
    check({name, "_busy_cyc"},  busy_cnt,  67);
    check({name, "_buttons"},   btn_v,     eb);
    check({name, "_pad"},       pad_v,     ep);
  endtask

  typedef struct {
    string      name;
    logic       np;
    logic [7:0] pressed;
    logic [7:0] exp_btn;
    logic       exp_pad;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int bad;
    vecs[0] = '{"a_right", 1'b0, 8'h81, 8'h81, 1'b1};
    vecs[1] = '{"none",    1'b0, 8'h00, 8'h00, 1'b1};
    vecs[2] = '{"up",      1'b0, 8'h10, 8'h10, 1'b1};
    vecs[3] = '{"no_pad",  1'b1, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{"all_on",  1'b0, 8'hFF, 8'h00, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_latch",   nes_latch,   0);
    check("rst_clk",     nes_clk,     0);
    check("rst_buttons", buttons,     8'h00);
    check("rst_valid",   valid,       0);
    check("rst_pad",     pad_present, 0);
    check("rst_busy",    busy,        0);

    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (busy || valid || nes_latch || nes_clk || pad_present || buttons != 8'h00) bad++;
    end
    check("idle_quiet", bad, 0);

    foreach (vecs[i])
      read_check(vecs[i].name, vecs[i].np, vecs[i].pressed, vecs[i].exp_btn, vecs[i].exp_pad, 1'b0);

    // triggers during a read are ignored; a trigger at N+80 starts the next read
    read_check("inject", 1'b0, 8'h81, 8'h81, 1'b1, 1'b1);
    read_check("b2b",    1'b0, 8'h42, 8'h42, 1'b1, 1'b0);

    // reset mid-read
    read_check("pre_rst", 1'b0, 8'h81, 8'h81, 1'b1, 1'b0);
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check("mid_clk_high", nes_clk, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_latch",   nes_latch,   0);
    check("mrst_clk",     nes_clk,     0);
    check("mrst_buttons", buttons,     8'h00);
    check("mrst_busy",    busy,        0);
    check("mrst_pad",     pad_present, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (valid || busy || buttons != 8'h00) bad++;
    end
    check("post_rst_quiet", bad, 0);
    read_check("after_rst", 1'b0, 8'h24, 8'h24, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      logic np;
      logic [7:0] p;
      np = ($urandom_range(0, 7) == 0);
      p  = 8'($urandom_range(0, 255));
      if (r == 7) p = 8'hFF;
      read_check($sformatf("rand%0d", r), np, p, ref_buttons(np, p), ref_present(np, p), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
